// File: rtl/msg_link_arbiter.sv
// msg_link_arbiter: shares one outbound valid/ready message link among
// NUM_REQ requesters. Arbitration is round-robin, and a multi-word message
// keeps the grant until its last word is accepted. A one-entry output register
// sustains one word per cycle while ready_i stays high.
// Optional build macro: MSG_ARB_FIXED_PRIORITY_EN makes the lowest-index
// valid requester win and removes the round-robin pointer. Locking is the same.
module msg_link_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      valid_o,
  output logic [DATA_W-1:0]         message_o,
  output logic                      last_o,
  input  logic                      ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic               load_en;
  logic               locked;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;
  logic               offer;
  logic               accept;

`ifndef MSG_ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  assign load_en = !valid_o || ready_i;
  assign locked  = (state_q == LOCKED);
  assign busy_o  = valid_o || locked;

`ifdef MSG_ARB_FIXED_PRIORITY_EN
  // Winner search: lowest-index valid requester (descending scan, last hit wins)
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int r = NUM_REQ - 1; r >= 0; r--) begin
      if (req_valid_i[r]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(r);
      end
    end
  end
`else
  // Winner search: first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!win_found && req_valid_i[r] &&
            (((int'(rr_ptr_q) + k) % NUM_REQ) == r)) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(r);
        end
      end
    end
  end
`endif

  // Handshake: the owner (or the fresh winner) is offered ready whenever the output register can load
  always_comb begin
    sel_idx     = locked ? own_q : win_idx;
    sel_valid   = 1'b0;
    sel_data    = '0;
    sel_last    = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (sel_idx == IDX_W'(r)) begin
        sel_valid = req_valid_i[r];
        sel_data  = req_data_i[r*DATA_W +: DATA_W];
        sel_last  = req_last_i[r];
      end
    end
    offer       = load_en && (locked || win_found) && !reset_i;
    accept      = offer && sel_valid;
    req_ready_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_ready_o[r] = offer && (sel_idx == IDX_W'(r));
    end
  end

  // Grant indication: one-hot owner while a message is in flight
  always_comb begin
    grant_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      grant_o[r] = locked && (own_q == IDX_W'(r));
    end
  end

  // Lock tracking: a non-last word locks to its sender, a last word releases and advances the pointer
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
`ifndef MSG_ARB_FIXED_PRIORITY_EN
    rr_ptr_d = rr_ptr_q;
`endif
    if (accept) begin
      if (sel_last) begin
        state_d  = UNLOCKED;
        own_d    = '0;
`ifndef MSG_ARB_FIXED_PRIORITY_EN
        rr_ptr_d = IDX_W'((int'(sel_idx) + 1) % NUM_REQ);
`endif
      end else begin
        state_d = LOCKED;
        own_d   = sel_idx;
      end
    end
  end

  // Arbitration state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= UNLOCKED;
      own_q    <= '0;
`ifndef MSG_ARB_FIXED_PRIORITY_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
`ifndef MSG_ARB_FIXED_PRIORITY_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Output register: loads on accept, drains on downstream ready, otherwise holds
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o   <= 1'b0;
      message_o <= '0;
      last_o    <= 1'b0;
    end else if (accept) begin
      valid_o   <= 1'b1;
      message_o <= sel_data;
      last_o    <= sel_last;
    end else if (ready_i) begin
      valid_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msg_link_arbiter.sv
// tb_msg_link_arbiter: directed self-checking bench for msg_link_arbiter with
// two requesters. Expected values are hand-computed per scenario.
module tb_msg_link_arbiter;

  logic        clk_i;
  logic        reset_i;
  logic [1:0]  req_valid_i;
  logic [63:0] req_data_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_ready_o;
  logic        valid_o;
  logic [31:0] message_o;
  logic        last_o;
  logic        ready_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  int checkCount;
  int errorCount;

  msg_link_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .valid_o     (valid_o),
    .message_o   (message_o),
    .last_o      (last_o),
    .ready_i     (ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [1:0] last,
                               input logic rdy);
    req_valid_i = valid;
    req_data_i  = {d1, d0};
    req_last_i  = last;
    ready_i     = rdy;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkRegs(input string tag, input logic vld, input logic [31:0] msg,
                           input logic lst, input logic [1:0] gnt);
    checkOutput({tag, ".valid"}, 64'(valid_o), 64'(vld));
    if (vld) begin
      checkOutput({tag, ".message"}, 64'(message_o), 64'(msg));
      checkOutput({tag, ".last"}, 64'(last_o), 64'(lst));
    end
    checkOutput({tag, ".grant"}, 64'(grant_o), 64'(gnt));
  endtask

  // Directed scenarios
  initial begin
    logic [31:0] expMsg;
    checkCount  = 0;
    errorCount  = 0;
    reset_i     = 1'b1;
    req_valid_i = 2'b11;
    req_data_i  = '0;
    req_last_i  = 2'b11;
    ready_i     = 1'b1;

    // Reset held with both requesters valid
    #2;
    checkOutput("rst.ready", 64'(req_ready_o), 64'h0);
    checkOutput("rst.valid", 64'(valid_o), 64'h0);
    checkOutput("rst.message", 64'(message_o), 64'h0);
    checkOutput("rst.grant", 64'(grant_o), 64'h0);
    checkOutput("rst.busy", 64'(busy_o), 64'h0);
    stepClock();
    stepClock();
    checkOutput("rst.ready_held", 64'(req_ready_o), 64'h0);
    reset_i = 1'b0;

    // Fairness: single-word messages from both, alternation starting with R0
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 32'hA000_0000 + 32'((i + 1) / 2),
                    32'hB000_0000 + 32'(i / 2), 2'b11, 1'b1);
      checkOutput($sformatf("fair%0d.ready", i), 64'(req_ready_o),
                  (i % 2 == 0) ? 64'h1 : 64'h2);
      stepClock();
      expMsg = (i % 2 == 0) ? 32'hA000_0000 + 32'(i / 2) : 32'hB000_0000 + 32'(i / 2);
      checkRegs($sformatf("fair%0d", i), 1'b1, expMsg, 1'b1, 2'b00);
    end

    // Locking: R0 single word moves pointer to R1, then R1 sends 3 words
    applyStimulus(2'b01, 32'h55, 32'h0, 2'b11, 1'b1);
    stepClock();
    checkRegs("lock.pre", 1'b1, 32'h55, 1'b1, 2'b00);
    applyStimulus(2'b11, 32'h99, 32'h11, 2'b01, 1'b1);
    checkOutput("lock.w1.ready", 64'(req_ready_o), 64'h2);
    stepClock();
    checkRegs("lock.w1", 1'b1, 32'h11, 1'b0, 2'b10);
    checkOutput("lock.w1.busy", 64'(busy_o), 64'h1);
    applyStimulus(2'b11, 32'h99, 32'h22, 2'b01, 1'b1);
    checkOutput("lock.w2.ready", 64'(req_ready_o), 64'h2);
    stepClock();
    checkRegs("lock.w2", 1'b1, 32'h22, 1'b0, 2'b10);
    applyStimulus(2'b11, 32'h99, 32'h33, 2'b11, 1'b1);
    checkOutput("lock.w3.ready", 64'(req_ready_o), 64'h2);
    stepClock();
    checkRegs("lock.w3", 1'b1, 32'h33, 1'b1, 2'b00);
    applyStimulus(2'b01, 32'h99, 32'h0, 2'b11, 1'b1);
    checkOutput("lock.r0.ready", 64'(req_ready_o), 64'h1);
    stepClock();
    checkRegs("lock.r0", 1'b1, 32'h99, 1'b1, 2'b00);

    // Backpressure: hold 0xDEADBEEF for 5 cycles with ready low
    applyStimulus(2'b10, 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b1);
    stepClock();
    checkRegs("bp.load", 1'b1, 32'hDEAD_BEEF, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b11, 32'h100, 32'h200, 2'b11, 1'b0);
      checkOutput($sformatf("bp%0d.ready", i), 64'(req_ready_o), 64'h0);
      stepClock();
      checkRegs($sformatf("bp%0d", i), 1'b1, 32'hDEAD_BEEF, 1'b1, 2'b00);
    end
    applyStimulus(2'b11, 32'h100, 32'h200, 2'b11, 1'b1);
    checkOutput("bp.release.ready", 64'(req_ready_o), 64'h1);
    stepClock();
    checkRegs("bp.release", 1'b1, 32'h100, 1'b1, 2'b00);

    // Owner stall: R0 locks, goes idle 4 cycles, R1 must not be served
    applyStimulus(2'b01, 32'h301, 32'h400, 2'b10, 1'b1);
    checkOutput("stall.w1.ready", 64'(req_ready_o), 64'h1);
    stepClock();
    checkRegs("stall.w1", 1'b1, 32'h301, 1'b0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b10, 32'h0, 32'h400, 2'b11, 1'b1);
      checkOutput($sformatf("stall%0d.ready", i), 64'(req_ready_o), 64'h1);
      stepClock();
      checkRegs($sformatf("stall%0d", i), 1'b0, 32'h0, 1'b0, 2'b01);
      checkOutput($sformatf("stall%0d.busy", i), 64'(busy_o), 64'h1);
    end
    applyStimulus(2'b11, 32'h302, 32'h400, 2'b11, 1'b1);
    checkOutput("stall.w2.ready", 64'(req_ready_o), 64'h1);
    stepClock();
    checkRegs("stall.w2", 1'b1, 32'h302, 1'b1, 2'b00);
    applyStimulus(2'b11, 32'h303, 32'h400, 2'b11, 1'b1);
    checkOutput("stall.r1.ready", 64'(req_ready_o), 64'h2);
    stepClock();
    checkRegs("stall.r1", 1'b1, 32'h400, 1'b1, 2'b00);

    // Reset mid-message: R1 locks, reset clears everything asynchronously
    applyStimulus(2'b10, 32'h0, 32'h500, 2'b01, 1'b1);
    checkOutput("mrst.w1.ready", 64'(req_ready_o), 64'h2);
    stepClock();
    checkRegs("mrst.w1", 1'b1, 32'h500, 1'b0, 2'b10);
    reset_i = 1'b1;
    #1;
    checkOutput("mrst.valid", 64'(valid_o), 64'h0);
    checkOutput("mrst.message", 64'(message_o), 64'h0);
    checkOutput("mrst.grant", 64'(grant_o), 64'h0);
    checkOutput("mrst.busy", 64'(busy_o), 64'h0);
    checkOutput("mrst.ready", 64'(req_ready_o), 64'h0);
    stepClock();
    reset_i = 1'b0;
    applyStimulus(2'b11, 32'h600, 32'h501, 2'b11, 1'b1);
    checkOutput("mrst.restart.ready", 64'(req_ready_o), 64'h1);
    stepClock();
    checkRegs("mrst.restart", 1'b1, 32'h600, 1'b1, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
